// File: rtl/zap_wb_arb2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: state encoding,
// master indices and the state-to-grant decode.
package zap_wb_arb2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_e;

  localparam logic MST_M0 = 1'b0;  // code master
  localparam logic MST_M1 = 1'b1;  // data master

  function automatic logic [1:0] state_to_gnt(input arb_state_e s);
    logic [1:0] g;
    g         = 2'b00;
    g[MST_M0] = (s == OWN_M0);
    g[MST_M1] = (s == OWN_M1);
    return g;
  endfunction

endpackage

// File: rtl/zap_wb_arb2_mux.sv
// Combinational request/response steering between the two masters and the
// shared slave, selected by the arbiter state register.
module zap_wb_arb2_mux
  import zap_wb_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                i_reset,
  input  arb_state_e          i_state,

  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic                i_m0_we,
  input  logic [ADDR_W-1:0]   i_m0_adr,
  input  logic [DATA_W-1:0]   i_m0_dat,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  output logic [DATA_W-1:0]   o_m0_dat,
  output logic                o_m0_ack,

  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  input  logic                i_m1_we,
  input  logic [ADDR_W-1:0]   i_m1_adr,
  input  logic [DATA_W-1:0]   i_m1_dat,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  output logic [DATA_W-1:0]   o_m1_dat,
  output logic                o_m1_ack,

  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [ADDR_W-1:0]   o_wb_adr,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic [DATA_W/8-1:0] o_wb_sel,
  input  logic [DATA_W-1:0]   i_wb_dat,
  input  logic                i_wb_ack
);

  logic own_m0;
  logic own_m1;

  // Reset overrides ownership so a transfer in flight is cut off immediately.
  assign own_m0 = !i_reset && (i_state == OWN_M0);
  assign own_m1 = !i_reset && (i_state == OWN_M1);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    if (own_m0) begin
      o_wb_cyc = i_m0_cyc;
      o_wb_stb = i_m0_stb;
      o_wb_we  = i_m0_we;
      o_wb_adr = i_m0_adr;
      o_wb_dat = i_m0_dat;
      o_wb_sel = i_m0_sel;
    end else if (own_m1) begin
      o_wb_cyc = i_m1_cyc;
      o_wb_stb = i_m1_stb;
      o_wb_we  = i_m1_we;
      o_wb_adr = i_m1_adr;
      o_wb_dat = i_m1_dat;
      o_wb_sel = i_m1_sel;
    end
  end

  // An ack landing in the cycle the owner drops cyc belongs to nobody.
  assign o_m0_ack = i_wb_ack && own_m0 && i_m0_cyc;
  assign o_m1_ack = i_wb_ack && own_m1 && i_m1_cyc;
  assign o_m0_dat = own_m0 ? i_wb_dat : '0;
  assign o_m1_dat = own_m1 ? i_wb_dat : '0;

endmodule

// File: rtl/zap_wb_arb2.sv
// Two-master Wishbone arbiter: non-preemptive ownership FSM, ties go to M1
// unless ZAP_WB_ARB_RR_EN is defined, which selects round-robin tie-break.
module zap_wb_arb2
  import zap_wb_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,

  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  input  logic                i_m0_we,
  input  logic [ADDR_W-1:0]   i_m0_adr,
  input  logic [DATA_W-1:0]   i_m0_dat,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  output logic [DATA_W-1:0]   o_m0_dat,
  output logic                o_m0_ack,

  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  input  logic                i_m1_we,
  input  logic [ADDR_W-1:0]   i_m1_adr,
  input  logic [DATA_W-1:0]   i_m1_dat,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  output logic [DATA_W-1:0]   o_m1_dat,
  output logic                o_m1_ack,

  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [ADDR_W-1:0]   o_wb_adr,
  output logic [DATA_W-1:0]   o_wb_dat,
  output logic [DATA_W/8-1:0] o_wb_sel,
  input  logic [DATA_W-1:0]   i_wb_dat,
  input  logic                i_wb_ack,

  output logic [1:0]          o_gnt,
  output logic                o_busy
);

  arb_state_e state_q;
  arb_state_e state_d;
  arb_state_e tie_winner;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) state_d = tie_winner;
        else if (i_m1_cyc)        state_d = OWN_M1;
        else if (i_m0_cyc)        state_d = OWN_M0;
      end
      // The owner keeps the bus until it drops cyc; handover is direct.
      OWN_M0:  if (!i_m0_cyc) state_d = i_m1_cyc ? OWN_M1 : IDLE;
      OWN_M1:  if (!i_m1_cyc) state_d = i_m0_cyc ? OWN_M0 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

`ifdef ZAP_WB_ARB_RR_EN
  logic last_served_q;
  logic last_served_d;

  always_comb begin
    last_served_d = last_served_q;
    if (state_d == OWN_M0)      last_served_d = MST_M0;
    else if (state_d == OWN_M1) last_served_d = MST_M1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) last_served_q <= MST_M1;
    else         last_served_q <= last_served_d;
  end

  assign tie_winner = (last_served_q == MST_M1) ? OWN_M0 : OWN_M1;
`else
  assign tie_winner = OWN_M1;
`endif

  assign o_gnt  = state_to_gnt(state_q);
  assign o_busy = (state_q != IDLE);

  zap_wb_arb2_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .i_reset  (i_reset),
    .i_state  (state_q),
    .i_m0_cyc (i_m0_cyc),
    .i_m0_stb (i_m0_stb),
    .i_m0_we  (i_m0_we),
    .i_m0_adr (i_m0_adr),
    .i_m0_dat (i_m0_dat),
    .i_m0_sel (i_m0_sel),
    .o_m0_dat (o_m0_dat),
    .o_m0_ack (o_m0_ack),
    .i_m1_cyc (i_m1_cyc),
    .i_m1_stb (i_m1_stb),
    .i_m1_we  (i_m1_we),
    .i_m1_adr (i_m1_adr),
    .i_m1_dat (i_m1_dat),
    .i_m1_sel (i_m1_sel),
    .o_m1_dat (o_m1_dat),
    .o_m1_ack (o_m1_ack),
    .o_wb_cyc (o_wb_cyc),
    .o_wb_stb (o_wb_stb),
    .o_wb_we  (o_wb_we),
    .o_wb_adr (o_wb_adr),
    .o_wb_dat (o_wb_dat),
    .o_wb_sel (o_wb_sel),
    .i_wb_dat (i_wb_dat),
    .i_wb_ack (i_wb_ack)
  );

endmodule

// File: doc/zap_wb_arb2.md
ZAP_WB_ARB2 -- requirements
Module: zap_wb_arb2

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 32: Wishbone data width.
REQ-003 SHALL have ports i_clk (in, 1, sole clock, rising edge) and i_reset (in, 1, synchronous active-high reset).
REQ-004 SHALL have ports i_m0_cyc, i_m0_stb, i_m0_we (in, 1 each) and i_m0_adr (in, ADDR_W), i_m0_dat (in, DATA_W), i_m0_sel (in, DATA_W/8): code master request.
REQ-005 SHALL have ports o_m0_dat (out, DATA_W) and o_m0_ack (out, 1): code master response.
REQ-006 SHALL have ports i_m1_* and o_m1_*, mirroring REQ-004/005: data master.
REQ-007 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we (out, 1 each) and o_wb_adr (out, ADDR_W), o_wb_dat (out, DATA_W), o_wb_sel (out, DATA_W/8): shared slave request.
REQ-008 SHALL have ports i_wb_dat (in, DATA_W) and i_wb_ack (in, 1): slave response.
REQ-009 SHALL have ports o_gnt (out, 2, one-hot or zero, current owner) and o_busy (out, 1, owner present).

Function
REQ-010 SHALL use a registered state machine with states IDLE, OWN_M0 and OWN_M1.
REQ-011 IDLE SHALL go to OWN_Mx on the next edge when any i_mx_cyc=1; with no request it SHALL stay in IDLE.
REQ-012 On a simultaneous IDLE request, fixed mode SHALL grant M1; round-robin mode SHALL grant the master not served last.
REQ-013 OWN_Mx SHALL be held for as long as i_mx_cyc=1, whatever the other master requests; grants are never preempted and bursts are never split.
REQ-014 When the owner drops cyc, the next state SHALL be OWN_My if the other master's cyc=1, else IDLE; the handover takes exactly one edge, with no idle cycle.
REQ-015 Slave outputs SHALL be a combinational mux of the owner's signals, selected by the state register; in IDLE all slave outputs SHALL be 0.
REQ-016 o_wb_cyc and o_wb_stb SHALL be the owner's cyc and stb ANDed with the state decode, so a dropped cyc is never forwarded late.
REQ-017 o_mx_ack SHALL equal i_wb_ack AND (state==OWN_Mx); o_mx_dat SHALL equal i_wb_dat when Mx owns the bus, else 0.
REQ-018 A non-owner SHALL never see ack=1, even if its stb is high.
REQ-019 Arbitration latency SHALL be one cycle, from cyc rising in IDLE to o_wb_cyc rising.
REQ-020 The last-served flag SHALL update on entry to OWN_Mx.
REQ-021 An ack arriving in the same cycle as the owner drops cyc SHALL be dropped and not routed to either master.

Reset
REQ-022 While i_reset=1 at a rising edge, state SHALL become IDLE and the last-served flag SHALL become M1.
REQ-023 While i_reset=1, all slave outputs and both master acks SHALL be 0 combinationally, including when reset is asserted mid-transfer.
REQ-024 In the first cycle after reset, o_gnt SHALL be 2'b00 and o_busy 0.

Configuration
REQ-025 Macro ZAP_WB_ARB_RR_EN defined: round-robin tie-break per REQ-012.
REQ-026 Macro ZAP_WB_ARB_RR_EN undefined: fixed priority, M1 (data) always wins ties, and the last-served flag is not implemented.

Structure
REQ-027 A shared package SHALL hold the state encoding constants (IDLE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2) and the master index constants.
REQ-028 One sub-module, zap_wb_arb2_mux, SHALL implement the combinational request/response steering from REQ-015 to REQ-017.
REQ-029 The state machine SHALL stay in the top module.

Verification
REQ-030 Idle bench: m0 cyc/stb, read of 0x100 -> o_wb_cyc=1 one cycle later, o_gnt=01; ack with data 0xDEADBEEF -> o_m0_dat=0xDEADBEEF and o_m1_ack=0.
REQ-031 Tie: both masters raise cyc in the same cycle -> o_gnt=10 (fixed mode); with ZAP_WB_ARB_RR_EN, repeated ties alternate 10, 01, 10.
REQ-032 Burst: m0 holds cyc for 4 acked beats while m1 requests -> m1 receives no ack and no grant until m0 drops cyc; o_gnt=10 on the edge after the drop, with no IDLE cycle.
REQ-033 Write: m1 writes 0xA5A5A5A5 with sel=4'b0011 to 0x7C8 -> slave sees identical adr/dat/sel/we=1, and readback returns low half 0xA5A5 merged with the old upper half.
REQ-034 Reset mid-transfer: i_reset=1 while OWN_M0 with stb high -> o_wb_cyc=0 in the same cycle, state IDLE after the edge, and no ack reaches m0.
REQ-035 Randomized-stall slave (ack on negedge, random withhold) for 10000 cycles -> no ack is ever misrouted and every request completes exactly once.
